alarm_trigger: RTL

//  Downstream consumer of the alarm-time editor. Compares the packed 20-bit alarm time

---
 rtl/alarm_pkg.sv | 22 ++
 rtl/beep_gen.sv | 36 +++
 rtl/alarm_trigger.sv | 135 +++++++++++++
 3 files changed

// File: rtl/alarm_pkg.sv
// Shared types for the alarm trigger: packed BCD time-of-day and FSM state encoding.
package alarm_pkg;

  localparam int TIME_W = 20;

  typedef struct packed {
    logic [1:0] h_tens;
    logic [3:0] h_ones;
    logic [2:0] m_tens;
    logic [3:0] m_ones;
    logic [2:0] s_tens;
    logic [3:0] s_ones;
  } time_t;

  typedef enum logic [1:0] {
    DISARMED = 2'd0,
    ARMED    = 2'd1,
    RINGING  = 2'd2,
    SNOOZE   = 2'd3
  } alarm_state_e;

endpackage

// File: rtl/beep_gen.sv
// Buzzer square-wave generator: half-period of BEEP_CYCLES clocks while enabled,
// starting high on the first enabled cycle; output forced low when disabled.
module beep_gen #(
  parameter int BEEP_CYCLES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic buzzer
);

  localparam int CNT_W = (BEEP_CYCLES > 1) ? $clog2(BEEP_CYCLES) : 1;
  localparam logic [CNT_W-1:0] BEEP_LAST = CNT_W'(BEEP_CYCLES - 1);

  logic [CNT_W-1:0] beep_cnt_reg;
  logic             tone_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beep_cnt_reg <= '0;
      tone_reg     <= 1'b0;
    end else if (!en) begin
      // Held primed so the first ringing cycle already drives the buzzer high.
      beep_cnt_reg <= '0;
      tone_reg     <= 1'b1;
    end else if (beep_cnt_reg == BEEP_LAST) begin
      beep_cnt_reg <= '0;
      tone_reg     <= ~tone_reg;
    end else begin
      beep_cnt_reg <= beep_cnt_reg + CNT_W'(1);
    end
  end

  assign buzzer = en & tone_reg;

endmodule

// File: rtl/alarm_trigger.sv
// Alarm sequencer: fires on the tick where cur_time first equals alarm_time, then handles
// stop / timeout / snooze. Define ALARM_SNOOZE_EN to build the SNOOZE state.
module alarm_trigger
  import alarm_pkg::*;
#(
  parameter int BEEP_CYCLES    = 2,
  parameter int RING_TIMEOUT_S = 60,
  parameter int SNOOZE_S       = 300
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_tick_1hz,
  input  logic [TIME_W-1:0] i_cur_time,
  input  logic [TIME_W-1:0] i_alarm_time,
  input  logic              i_alarm_wr_en,
  input  logic              i_arm_toggle,
  input  logic              i_stop,
  input  logic              i_snooze,
  output logic              o_buzzer,
  output logic              o_armed,
  output logic              o_ringing,
  output logic              o_snoozing
);

  localparam int RING_W = $clog2(RING_TIMEOUT_S + 1);
  localparam logic [RING_W-1:0] RING_LAST = RING_W'(RING_TIMEOUT_S - 1);

  alarm_state_e      state_reg, state_next;
  time_t             cur_t, alarm_t;
  logic              match, match_reg, trigger, ring_done;
  logic [RING_W-1:0] ring_cnt_reg;

  assign cur_t   = time_t'(i_cur_time);
  assign alarm_t = time_t'(i_alarm_time);

  // Rising edge of the match, sampled only on ticks, so a stopped clock cannot re-fire.
  assign match     = (cur_t == alarm_t);
  assign trigger   = i_tick_1hz & match & ~match_reg;
  assign ring_done = i_tick_1hz & (ring_cnt_reg == RING_LAST);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      match_reg <= 1'b0;
    end else if (i_tick_1hz) begin
      match_reg <= match;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ring_cnt_reg <= '0;
    end else if (state_reg != RINGING) begin
      ring_cnt_reg <= '0;
    end else if (i_tick_1hz && (ring_cnt_reg != RING_LAST)) begin
      ring_cnt_reg <= ring_cnt_reg + RING_W'(1);
    end
  end

`ifdef ALARM_SNOOZE_EN
  localparam int SNZ_W = $clog2(SNOOZE_S + 1);
  localparam logic [SNZ_W-1:0] SNZ_LAST = SNZ_W'(SNOOZE_S - 1);

  logic [SNZ_W-1:0] snz_cnt_reg;
  logic             snz_done;

  assign snz_done = i_tick_1hz & (snz_cnt_reg == SNZ_LAST);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      snz_cnt_reg <= '0;
    end else if (state_reg != SNOOZE) begin
      snz_cnt_reg <= '0;
    end else if (i_tick_1hz && (snz_cnt_reg != SNZ_LAST)) begin
      snz_cnt_reg <= snz_cnt_reg + SNZ_W'(1);
    end
  end

  assign o_snoozing = (state_reg == SNOOZE);
`else
  logic unused_snooze;
  assign unused_snooze = i_snooze ^ (SNOOZE_S < 1);
  assign o_snoozing    = 1'b0;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_reg <= DISARMED;
    end else begin
      state_reg <= state_next;
    end
  end

  // Branch order encodes priority: arm_toggle > stop > alarm_wr_en > snooze > timeout/trigger.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      DISARMED: begin
        if (i_arm_toggle) state_next = ARMED;
      end
      ARMED: begin
        if (i_arm_toggle)                    state_next = DISARMED;
        else if (trigger && !i_alarm_wr_en)  state_next = RINGING;
      end
      RINGING: begin
        if (i_arm_toggle)                    state_next = DISARMED;
        else if (i_stop || i_alarm_wr_en)    state_next = ARMED;
`ifdef ALARM_SNOOZE_EN
        else if (i_snooze)                   state_next = SNOOZE;
`endif
        else if (ring_done)                  state_next = ARMED;
      end
`ifdef ALARM_SNOOZE_EN
      SNOOZE: begin
        if (i_arm_toggle)                    state_next = DISARMED;
        else if (i_stop || i_alarm_wr_en)    state_next = ARMED;
        else if (snz_done)                   state_next = RINGING;
      end
`endif
      default: state_next = DISARMED;
    endcase
  end

  assign o_armed   = (state_reg != DISARMED);
  assign o_ringing = (state_reg == RINGING);

  beep_gen #(
    .BEEP_CYCLES(BEEP_CYCLES)
  ) u_beep_gen (
    .clk   (i_clk),
    .rst_n (i_rst_n),
    .en    (state_reg == RINGING),
    .buzzer(o_buzzer)
  );

endmodule
